// File: rtl/pht_table.sv
`default_nettype none
// ============================================================================
// Module      : pht_table
// Description : Pattern history table of 2-bit saturating counters for the
//               two-bit dynamic branch predictor. Registered lookups, and a
//               two-stage read/write-back update loop through an external
//               registered counter FSM, with forwarding of the pending write.
// Revision    : 1.0 - initial release
// ============================================================================
module pht_table #(
    parameter int         PC_W        = 32,
    parameter int         IDX_W       = 6,
    parameter logic [1:0] RESET_STATE = 2'b01
) (
    input  logic            clk,
    input  logic            rst,
    // prediction lookup
    input  logic            lkp_valid,
    input  logic [PC_W-1:0] lkp_pc,
    output logic            pred_valid,
    output logic            pred_taken,
    output logic [1:0]      pred_state,
    // branch resolution
    input  logic            upd_valid,
    input  logic [PC_W-1:0] upd_pc,
    input  logic            upd_taken,
    // external two-bit update FSM
    output logic            fsm_actual,
    output logic [1:0]      fsm_read_state,
    input  logic [1:0]      fsm_next_state
);

    localparam int c_DEPTH = 1 << IDX_W;

    logic [1:0]       r_table [c_DEPTH];
    logic             r_wr_valid;
    logic [IDX_W-1:0] r_wr_idx;
    logic             r_pred_valid;
    logic [1:0]       r_pred_state;

    logic [IDX_W-1:0] w_upd_idx;
    logic [IDX_W-1:0] w_lkp_idx;
    logic             w_upd_fwd;
    logic             w_lkp_fwd;
    logic [1:0]       w_upd_cur;
    logic [1:0]       w_lkp_cur;

    // PCs are word aligned; the low two bits and everything above the index
    // are intentionally dropped, so distant branches alias onto one counter.
    assign w_upd_idx = upd_pc[IDX_W+1:2];
    assign w_lkp_idx = lkp_pc[IDX_W+1:2];

    logic w_unused_pc_bits;
    assign w_unused_pc_bits = ^{upd_pc[PC_W-1:IDX_W+2], upd_pc[1:0],
                                lkp_pc[PC_W-1:IDX_W+2], lkp_pc[1:0]};

    // The write pending from last cycle's update is not in the array yet, so
    // both read ports take the FSM output directly when they hit its index.
    always_comb begin
        w_upd_fwd = r_wr_valid && (r_wr_idx == w_upd_idx);
        w_lkp_fwd = r_wr_valid && (r_wr_idx == w_lkp_idx);
        w_upd_cur = w_upd_fwd ? fsm_next_state : r_table[w_upd_idx];
        w_lkp_cur = w_lkp_fwd ? fsm_next_state : r_table[w_lkp_idx];
    end

    // Drive the FSM inputs for the branch being resolved this cycle.
    always_comb begin
        fsm_actual     = 1'b0;
        fsm_read_state = 2'b00;
        if (upd_valid) begin
            fsm_actual     = upd_taken;
            fsm_read_state = w_upd_cur;
        end
    end

    // Counter array: reset to RESET_STATE, commit the FSM result one cycle
    // after the update was presented.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_table[i] <= RESET_STATE;
            end
        end else if (r_wr_valid) begin
            r_table[r_wr_idx] <= fsm_next_state;
        end
    end

    // Remember which entry the FSM is working on so it can be written back.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_valid <= 1'b0;
            r_wr_idx   <= '0;
        end else begin
            r_wr_valid <= upd_valid;
            if (upd_valid) begin
                r_wr_idx <= w_upd_idx;
            end
        end
    end

    // Registered prediction; the state holds while no lookup is requested.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pred_valid <= 1'b0;
            r_pred_state <= 2'b00;
        end else begin
            r_pred_valid <= lkp_valid;
            if (lkp_valid) begin
                r_pred_state <= w_lkp_cur;
            end
        end
    end

    assign pred_valid = r_pred_valid;
    assign pred_state = r_pred_state;
    assign pred_taken = r_pred_state[1];

endmodule
`default_nettype wire

// File: tb/tb_pht_table.sv
`default_nettype none
// ============================================================================
// Module      : tb_pht_table
// Description : Directed, table-driven self-checking bench for pht_table,
//               including a behavioural model of the registered 2-bit FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pht_table;

    logic        clk = 1'b0;
    logic        rst;
    logic        lkp_valid;
    logic [31:0] lkp_pc;
    logic        pred_valid;
    logic        pred_taken;
    logic [1:0]  pred_state;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic        fsm_actual;
    logic [1:0]  fsm_read_state;
    logic [1:0]  fsm_next_state = 2'b00;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pht_table #(.PC_W(32), .IDX_W(6), .RESET_STATE(2'b01)) dut (
        .clk            (clk),
        .rst            (rst),
        .lkp_valid      (lkp_valid),
        .lkp_pc         (lkp_pc),
        .pred_valid     (pred_valid),
        .pred_taken     (pred_taken),
        .pred_state     (pred_state),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .fsm_actual     (fsm_actual),
        .fsm_read_state (fsm_read_state),
        .fsm_next_state (fsm_next_state)
    );

    // Registered two-bit saturating counter, as the real FSM behaves.
    always @(posedge clk) begin
        if (fsm_actual)
            fsm_next_state <= (fsm_read_state == 2'b11) ? 2'b11 : fsm_read_state + 2'b01;
        else
            fsm_next_state <= (fsm_read_state == 2'b00) ? 2'b00 : fsm_read_state - 2'b01;
    end

    typedef struct {
        logic        lkp_v;
        logic [31:0] lkp_pc;
        logic        upd_v;
        logic [31:0] upd_pc;
        logic        upd_t;
        logic [1:0]  e_rs;   // fsm_read_state during the cycle
        logic        e_act;  // fsm_actual during the cycle
        logic        e_pv;   // pred_valid after the edge
        logic [1:0]  e_ps;   // pred_state after the edge
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        lkp_valid = 1'b0; lkp_pc = '0;
        upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0;
    endtask

    initial begin
        //                 lkp  lkp_pc    upd  upd_pc    tk  rs     act pv  ps
        vecs[0]  = '{1'b0, 32'h0,   1'b1, 32'h10,  1'b1, 2'b01, 1'b1, 1'b0, 2'b01};
        vecs[1]  = '{1'b1, 32'h10,  1'b1, 32'h10,  1'b1, 2'b10, 1'b1, 1'b1, 2'b10};
        vecs[2]  = '{1'b1, 32'h10,  1'b1, 32'h10,  1'b1, 2'b11, 1'b1, 1'b1, 2'b11};
        vecs[3]  = '{1'b0, 32'h0,   1'b1, 32'h10,  1'b1, 2'b11, 1'b1, 1'b0, 2'b11};
        vecs[4]  = '{1'b0, 32'h0,   1'b1, 32'h10,  1'b0, 2'b11, 1'b0, 1'b0, 2'b11};
        vecs[5]  = '{1'b0, 32'h0,   1'b1, 32'h10,  1'b0, 2'b10, 1'b0, 1'b0, 2'b11};
        vecs[6]  = '{1'b0, 32'h0,   1'b1, 32'h10,  1'b0, 2'b01, 1'b0, 1'b0, 2'b11};
        vecs[7]  = '{1'b0, 32'h0,   1'b1, 32'h10,  1'b0, 2'b00, 1'b0, 1'b0, 2'b11};
        vecs[8]  = '{1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 2'b00, 1'b0, 1'b0, 2'b11};
        vecs[9]  = '{1'b1, 32'h10,  1'b0, 32'h0,   1'b0, 2'b00, 1'b0, 1'b1, 2'b00};
        vecs[10] = '{1'b1, 32'h8,   1'b1, 32'h104, 1'b1, 2'b01, 1'b1, 1'b1, 2'b01};
        vecs[11] = '{1'b1, 32'h4,   1'b0, 32'h0,   1'b0, 2'b00, 1'b0, 1'b1, 2'b10};
        vecs[12] = '{1'b1, 32'h4,   1'b1, 32'h207, 1'b0, 2'b10, 1'b0, 1'b1, 2'b10};
        vecs[13] = '{1'b1, 32'h5,   1'b0, 32'h0,   1'b0, 2'b00, 1'b0, 1'b1, 2'b01};
        vecs[14] = '{1'b0, 32'h4,   1'b0, 32'h10,  1'b1, 2'b00, 1'b0, 1'b0, 2'b01};

        // Reset and reset-state outputs
        idle_inputs();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        #1;
        check("reset_pred_valid", 32'(pred_valid), 32'h0);
        check("reset_pred_state", 32'(pred_state), 32'h0);
        check("reset_pred_taken", 32'(pred_taken), 32'h0);
        check("reset_fsm_read",   32'(fsm_read_state), 32'h0);

        // Every entry reads back as weakly not taken
        for (int i = 0; i < 64; i++) begin
            lkp_valid = 1'b1; lkp_pc = 32'(4 * i);
            tick();
            check("sweep_pred_valid", 32'(pred_valid), 32'h1);
            check("sweep_pred_state", 32'(pred_state), 32'h1);
            check("sweep_pred_taken", 32'(pred_taken), 32'h0);
        end
        idle_inputs();
        tick();
        check("sweep_end_valid", 32'(pred_valid), 32'h0);

        // Vector table: updates, forwarding, saturation, aliasing
        for (int i = 0; i < 15; i++) begin
            lkp_valid = vecs[i].lkp_v; lkp_pc = vecs[i].lkp_pc;
            upd_valid = vecs[i].upd_v; upd_pc = vecs[i].upd_pc; upd_taken = vecs[i].upd_t;
            #1;
            check($sformatf("v%0d_fsm_read_state", i), 32'(fsm_read_state), 32'(vecs[i].e_rs));
            check($sformatf("v%0d_fsm_actual", i),     32'(fsm_actual),     32'(vecs[i].e_act));
            tick();
            check($sformatf("v%0d_pred_valid", i), 32'(pred_valid), 32'(vecs[i].e_pv));
            check($sformatf("v%0d_pred_state", i), 32'(pred_state), 32'(vecs[i].e_ps));
            check($sformatf("v%0d_pred_taken", i), 32'(pred_taken), 32'(vecs[i].e_ps[1]));
        end
        idle_inputs();
        tick();

        // Reset arriving while a write is pending drops that write
        upd_valid = 1'b1; upd_pc = 32'h10; upd_taken = 1'b1;
        #1;
        check("rstpend_fsm_read", 32'(fsm_read_state), 32'h0);
        tick();
        rst = 1'b1;
        lkp_valid = 1'b1; lkp_pc = 32'h10;
        upd_valid = 1'b1; upd_pc = 32'h10; upd_taken = 1'b1;
        tick();
        rst = 1'b0;
        idle_inputs();
        check("rstpend_pred_valid", 32'(pred_valid), 32'h0);
        check("rstpend_pred_state", 32'(pred_state), 32'h0);
        check("rstpend_wr_valid",   32'(dut.r_wr_valid), 32'h0);
        tick();
        lkp_valid = 1'b1; lkp_pc = 32'h10;
        tick();
        check("rstpend_entry4", 32'(pred_state), 32'h1);
        lkp_pc = 32'h0;
        tick();
        check("rstpend_entry0", 32'(pred_state), 32'h1);
        lkp_pc = 32'h4;
        tick();
        check("rstpend_entry1", 32'(pred_state), 32'h1);
        idle_inputs();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
